rs_credit_scheduler: RTL and testbench

- Credit-based flow controller for the three reservation stations (ALU, LSU, BRU) fed by the dual-slot dispatch stage.
- Tracks free entries per RS using the 2-wide dispatch and 1-wide issue events, and generates `stall_dispatch` when a rename group does not fit.
- Sequences flush recovery through a drain window before dispatch resumes.
- Sits between rename/ROB-allocation and the dispatch/RS block.

---
 rtl/rs_credit_scheduler_if.sv | 45 ++++
 rtl/rs_credit_scheduler.sv | 138 +++++++++++++
 tb/tb_rs_credit_scheduler.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/rs_credit_scheduler_if.sv
// Handshake bundle between rename/dispatch and the RS credit scheduler.
// RS_CREDIT_STATS_EN adds the stall statistics counters to the bundle.
interface rs_credit_scheduler_if #(
   parameter int CNT_WIDTH = 5
);
   logic                 flush_i;
   logic                 ext_stall_i;
   logic                 slot_valid_0_i;
   logic [1:0]           slot_class_0_i;
   logic                 slot_valid_1_i;
   logic [1:0]           slot_class_1_i;
   logic                 issue_alu_i;
   logic                 issue_lsu_i;
   logic                 issue_bru_i;
   logic                 stall_dispatch_o;
   logic [CNT_WIDTH-1:0] credit_alu_o;
   logic [CNT_WIDTH-1:0] credit_lsu_o;
   logic [CNT_WIDTH-1:0] credit_bru_o;
   logic [1:0]           sched_state_o;
   logic                 credit_err_o;
`ifdef RS_CREDIT_STATS_EN
   logic [31:0]          stat_stall_cycles_o;
   logic [31:0]          stat_credit_stalls_o;
`endif

   modport slave (
      input  flush_i, ext_stall_i, slot_valid_0_i, slot_class_0_i,
             slot_valid_1_i, slot_class_1_i, issue_alu_i, issue_lsu_i, issue_bru_i,
`ifdef RS_CREDIT_STATS_EN
      output stat_stall_cycles_o, stat_credit_stalls_o,
`endif
      output stall_dispatch_o, credit_alu_o, credit_lsu_o, credit_bru_o,
             sched_state_o, credit_err_o
   );

   modport master (
      output flush_i, ext_stall_i, slot_valid_0_i, slot_class_0_i,
             slot_valid_1_i, slot_class_1_i, issue_alu_i, issue_lsu_i, issue_bru_i,
`ifdef RS_CREDIT_STATS_EN
      input  stat_stall_cycles_o, stat_credit_stalls_o,
`endif
      input  stall_dispatch_o, credit_alu_o, credit_lsu_o, credit_bru_o,
             sched_state_o, credit_err_o
   );
endinterface

// File: rtl/rs_credit_scheduler.sv
// Credit-based flow control for the ALU/LSU/BRU reservation stations with flush drain.
// Define RS_CREDIT_STATS_EN to add the stall statistics counters.
module rs_credit_scheduler #(
   parameter int NUM_RS_ENTRIES = 16,
   parameter int CNT_WIDTH      = 5,
   parameter int DRAIN_CYCLES   = 2
) (
   input logic                   clk,
   input logic                   rst_n,
   rs_credit_scheduler_if.slave  bus
);
   typedef enum logic [1:0] {INIT = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_e;

   localparam logic [CNT_WIDTH-1:0] FULL       = CNT_WIDTH'(NUM_RS_ENTRIES);
   localparam logic [CNT_WIDTH+1:0] SUM_MAX    = (CNT_WIDTH+2)'(NUM_RS_ENTRIES);
   localparam logic [3:0]           DRAIN_LOAD = 4'(DRAIN_CYCLES);

   state_e                          state_q;
   logic [3:0]                      drainCnt_q;
   logic [2:0][CNT_WIDTH-1:0]       credit_q, credit_d;
   logic                            creditErr_q, creditErr_d;
   logic [2:0][1:0]                 need;
   logic [2:0]                      issueVec;
   logic [2:0][CNT_WIDTH+1:0]       sum;
   logic [2:0]                      underflow;
   logic                            needOver, stall, dispOk;

   // Index 0/1/2 = ALU/LSU/BRU, matching the slot class encoding; class 3 never matches.
   always_comb begin
      issueVec = {bus.issue_bru_i, bus.issue_lsu_i, bus.issue_alu_i};
      needOver = 1'b0;
      for (int c = 0; c < 3; c++) begin
         need[c] = {1'b0, bus.slot_valid_0_i && (bus.slot_class_0_i == 2'(c))}
                 + {1'b0, bus.slot_valid_1_i && (bus.slot_class_1_i == 2'(c))};
         if ({{(CNT_WIDTH-2){1'b0}}, need[c]} > credit_q[c]) needOver = 1'b1;
      end
      stall  = (state_q != RUN) || bus.flush_i || bus.ext_stall_i || needOver;
      dispOk = !stall && (bus.slot_valid_0_i || bus.slot_valid_1_i);
   end

   // Net dispatch consumption against issue return; a result above full is a spurious issue.
   always_comb begin
      credit_d    = credit_q;
      creditErr_d = creditErr_q;
      for (int c = 0; c < 3; c++) begin
         sum[c] = {2'b00, credit_q[c]}
                + {{(CNT_WIDTH+1){1'b0}}, issueVec[c]}
                - (dispOk ? {{CNT_WIDTH{1'b0}}, need[c]} : '0);
         underflow[c] = sum[c][CNT_WIDTH+1];
         if (bus.flush_i) begin
            credit_d[c] = FULL;
         end else if (!underflow[c] && (sum[c] > SUM_MAX)) begin
            credit_d[c] = FULL;
            creditErr_d = 1'b1;
         end else begin
            credit_d[c] = sum[c][CNT_WIDTH-1:0];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         credit_q    <= {3{FULL}};
         creditErr_q <= 1'b0;
      end else begin
         credit_q    <= credit_d;
         creditErr_q <= creditErr_d;
      end
   end

   // Drain counter reloads on every flush; RUN resumes once it has counted down to 1.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= INIT;
         drainCnt_q <= '0;
      end else begin
         case (state_q)
            INIT: begin
               if (bus.flush_i) begin
                  state_q    <= DRAIN;
                  drainCnt_q <= DRAIN_LOAD;
               end else begin
                  state_q <= RUN;
               end
            end
            RUN: begin
               if (bus.flush_i) begin
                  state_q    <= DRAIN;
                  drainCnt_q <= DRAIN_LOAD;
               end
            end
            DRAIN: begin
               if (bus.flush_i) begin
                  drainCnt_q <= DRAIN_LOAD;
               end else if (drainCnt_q <= 4'd1) begin
                  state_q    <= RUN;
                  drainCnt_q <= '0;
               end else begin
                  drainCnt_q <= drainCnt_q - 4'd1;
               end
            end
            default: begin
               state_q    <= INIT;
               drainCnt_q <= '0;
            end
         endcase
      end
   end

   underflowCheck: assert property (@(posedge clk) disable iff (!rst_n)
      !bus.flush_i |-> (underflow == 3'b000));

`ifdef RS_CREDIT_STATS_EN
   logic [31:0] statStall_q, statCredit_q;

   // Only stalls of a live group in RUN count; flush cycles hold both counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         statStall_q  <= '0;
         statCredit_q <= '0;
      end else if ((state_q == RUN) && stall && !bus.flush_i
                   && (bus.slot_valid_0_i || bus.slot_valid_1_i)) begin
         statStall_q <= statStall_q + 32'd1;
         if (!bus.ext_stall_i) statCredit_q <= statCredit_q + 32'd1;
      end
   end

   assign bus.stat_stall_cycles_o  = statStall_q;
   assign bus.stat_credit_stalls_o = statCredit_q;
`endif

   assign bus.stall_dispatch_o = stall;
   assign bus.credit_alu_o     = credit_q[0];
   assign bus.credit_lsu_o     = credit_q[1];
   assign bus.credit_bru_o     = credit_q[2];
   assign bus.sched_state_o    = state_q;
   assign bus.credit_err_o     = creditErr_q;
endmodule

// File: tb/tb_rs_credit_scheduler.sv
// Bench for rs_credit_scheduler: directed vector table, async reset, optional stats, random vs model.
module tb_rs_credit_scheduler;
   localparam int NUM   = 16;
   localparam int CW    = 5;
   localparam int DRAIN = 2;
   localparam logic [1:0] A = 2'd0, L = 2'd1, B = 2'd2, N = 2'd3;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   nTests = 0;
   int   nFail = 0;

   always #5 clk = ~clk;

   rs_credit_scheduler_if #(.CNT_WIDTH(CW)) busIf ();

   rs_credit_scheduler #(.NUM_RS_ENTRIES(NUM), .CNT_WIDTH(CW), .DRAIN_CYCLES(DRAIN)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (busIf)
   );

   typedef struct {
      logic       v0;
      logic [1:0] c0;
      logic       v1;
      logic [1:0] c1;
      logic [2:0] iss;
      logic       fl;
      logic       ext;
      logic       expStall;
      int         expAlu, expLsu, expBru, expState;
      logic       expErr;
   } vec_t;

   vec_t vecs[$];

   // Reference model: credits as plain integers, mode derived from edge counts.
   int mCredit[3];
   bit mErr;
   int sinceReset;
   int quiet;

   task automatic checkOutput(input string name, input int actual, input int expected);
      nTests++;
      if (actual !== expected) begin
         nFail++;
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic drive(input logic v0, input logic [1:0] c0, input logic v1, input logic [1:0] c1,
                        input logic [2:0] iss, input logic fl, input logic ext);
      busIf.slot_valid_0_i = v0;
      busIf.slot_class_0_i = c0;
      busIf.slot_valid_1_i = v1;
      busIf.slot_class_1_i = c1;
      busIf.issue_alu_i    = iss[0];
      busIf.issue_lsu_i    = iss[1];
      busIf.issue_bru_i    = iss[2];
      busIf.flush_i        = fl;
      busIf.ext_stall_i    = ext;
   endtask

   function automatic void addVec(input logic v0, input logic [1:0] c0, input logic v1,
                                  input logic [1:0] c1, input logic [2:0] iss, input logic fl,
                                  input logic ext, input logic st, input int ea, input int el,
                                  input int eb, input int es, input logic ee);
      vec_t v;
      v.v0 = v0; v.c0 = c0; v.v1 = v1; v.c1 = c1; v.iss = iss; v.fl = fl; v.ext = ext;
      v.expStall = st; v.expAlu = ea; v.expLsu = el; v.expBru = eb; v.expState = es; v.expErr = ee;
      vecs.push_back(v);
   endfunction

   // Called at a negedge: drive, check the combinational stall, then the registered results.
   task automatic applyStimulus(input vec_t v, input int idx);
      drive(v.v0, v.c0, v.v1, v.c1, v.iss, v.fl, v.ext);
      #1;
      checkOutput($sformatf("vec%0d stall", idx), int'(busIf.stall_dispatch_o), int'(v.expStall));
      @(posedge clk);
      #1;
      checkOutput($sformatf("vec%0d alu", idx), int'(busIf.credit_alu_o), v.expAlu);
      checkOutput($sformatf("vec%0d lsu", idx), int'(busIf.credit_lsu_o), v.expLsu);
      checkOutput($sformatf("vec%0d bru", idx), int'(busIf.credit_bru_o), v.expBru);
      checkOutput($sformatf("vec%0d state", idx), int'(busIf.sched_state_o), v.expState);
      checkOutput($sformatf("vec%0d err", idx), int'(busIf.credit_err_o), int'(v.expErr));
      @(negedge clk);
   endtask

   function automatic int needOf(input int c, input logic v0, input logic [1:0] c0,
                                 input logic v1, input logic [1:0] c1);
      return ((v0 && int'(c0) == c) ? 1 : 0) + ((v1 && int'(c1) == c) ? 1 : 0);
   endfunction

   function automatic int modelState();
      if (sinceReset == 0) return 0;
      if (quiet < DRAIN) return 2;
      return 1;
   endfunction

   task automatic resetModel();
      for (int c = 0; c < 3; c++) mCredit[c] = NUM;
      mErr = 1'b0;
      sinceReset = 0;
      quiet = DRAIN;
   endtask

   task automatic doReset();
      @(negedge clk);
      rst_n = 1'b0;
      drive(1'b0, N, 1'b0, N, 3'b000, 1'b0, 1'b0);
      @(negedge clk);
      @(negedge clk);
      resetModel();
      rst_n = 1'b1;
   endtask

   initial begin
      int ea, el, eb;
      int pendingDisp;
      logic v0, v1, fl, ext, mStall, ok;
      logic [1:0] c0, c1;
      logic [2:0] iss;
      int nd;

      drive(1'b0, N, 1'b0, N, 3'b000, 1'b0, 1'b0);

      // Directed table, hand-derived from the credit and drain rules.
      addVec(1, A, 0, N, 3'b000, 0, 0, 1, 16, 16, 16, 1, 0);
      for (int k = 1; k <= 8; k++) addVec(1, A, 1, A, 3'b000, 0, 0, 0, 16 - 2 * k, 16, 16, 1, 0);
      addVec(1, A, 1, A, 3'b000, 0, 0, 1, 0, 16, 16, 1, 0);
      addVec(1, A, 1, A, 3'b001, 0, 0, 1, 1, 16, 16, 1, 0);
      addVec(1, A, 1, A, 3'b000, 0, 0, 1, 1, 16, 16, 1, 0);
      addVec(1, A, 1, N, 3'b000, 0, 0, 0, 0, 16, 16, 1, 0);
      for (int k = 1; k <= 7; k++) addVec(1, L, 1, L, 3'b000, 0, 0, 0, 0, 16 - 2 * k, 16, 1, 0);
      addVec(1, L, 0, N, 3'b000, 0, 0, 0, 0, 1, 16, 1, 0);
      addVec(1, L, 1, L, 3'b010, 0, 0, 1, 0, 2, 16, 1, 0);
      addVec(1, L, 1, L, 3'b000, 0, 0, 0, 0, 0, 16, 1, 0);
      for (int k = 1; k <= 5; k++) addVec(1, B, 1, B, 3'b000, 0, 0, 0, 0, 0, 16 - 2 * k, 1, 0);
      addVec(1, B, 0, N, 3'b000, 0, 0, 0, 0, 0, 5, 1, 0);
      addVec(1, B, 0, N, 3'b100, 0, 0, 0, 0, 0, 5, 1, 0);
      addVec(1, A, 0, N, 3'b001, 1, 0, 1, 16, 16, 16, 2, 0);
      addVec(1, A, 0, N, 3'b000, 0, 0, 1, 16, 16, 16, 2, 0);
      addVec(1, A, 0, N, 3'b000, 0, 0, 1, 16, 16, 16, 1, 0);
      addVec(1, A, 0, N, 3'b000, 0, 0, 0, 15, 16, 16, 1, 0);
      addVec(0, N, 0, N, 3'b000, 1, 0, 1, 16, 16, 16, 2, 0);
      addVec(0, N, 0, N, 3'b000, 0, 0, 1, 16, 16, 16, 2, 0);
      addVec(0, N, 0, N, 3'b000, 1, 0, 1, 16, 16, 16, 2, 0);
      addVec(0, N, 0, N, 3'b000, 0, 0, 1, 16, 16, 16, 2, 0);
      addVec(0, N, 0, N, 3'b000, 0, 0, 1, 16, 16, 16, 1, 0);
      addVec(1, A, 0, N, 3'b000, 0, 1, 1, 16, 16, 16, 1, 0);
      addVec(0, N, 0, N, 3'b100, 0, 0, 0, 16, 16, 16, 1, 1);
      addVec(1, N, 1, N, 3'b000, 0, 0, 0, 16, 16, 16, 1, 1);
      addVec(1, A, 1, A, 3'b000, 0, 0, 0, 14, 16, 16, 1, 1);
      addVec(1, L, 1, L, 3'b000, 0, 0, 0, 14, 14, 16, 1, 1);

      @(negedge clk);
      checkOutput("reset state", int'(busIf.sched_state_o), 0);
      checkOutput("reset alu", int'(busIf.credit_alu_o), NUM);
      checkOutput("reset stall", int'(busIf.stall_dispatch_o), 1);
      checkOutput("reset err", int'(busIf.credit_err_o), 0);
      rst_n = 1'b1;
      foreach (vecs[i]) applyStimulus(vecs[i], i);

      // Async reset mid-dispatch takes effect without a clock edge.
      drive(1'b1, A, 1'b1, A, 3'b000, 1'b0, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("async state", int'(busIf.sched_state_o), 0);
      checkOutput("async alu", int'(busIf.credit_alu_o), NUM);
      checkOutput("async lsu", int'(busIf.credit_lsu_o), NUM);
      checkOutput("async err", int'(busIf.credit_err_o), 0);
      checkOutput("async stall", int'(busIf.stall_dispatch_o), 1);

`ifdef RS_CREDIT_STATS_EN
      doReset();
      drive(1'b1, A, 1'b1, A, 3'b000, 1'b0, 1'b0);
      for (int k = 0; k < 14; k++) @(negedge clk);
      checkOutput("stat credit stalls", int'(busIf.stat_credit_stalls_o), 5);
      checkOutput("stat stall cycles", int'(busIf.stat_stall_cycles_o), 5);
`endif

      // Randomised run against the reference model.
      doReset();
      for (int cyc = 0; cyc < 3000; cyc++) begin
         v0  = 1'($urandom_range(0, 1));
         v1  = 1'($urandom_range(0, 1));
         c0  = 2'($urandom_range(0, 3));
         c1  = 2'($urandom_range(0, 3));
         iss[0] = ($urandom_range(0, 2) == 0);
         iss[1] = ($urandom_range(0, 2) == 0);
         iss[2] = ($urandom_range(0, 2) == 0);
         fl  = ($urandom_range(0, 39) == 0);
         ext = ($urandom_range(0, 7) == 0);
         drive(v0, c0, v1, c1, iss, fl, ext);
         #1;
         mStall = (modelState() != 1) || fl || ext;
         for (int c = 0; c < 3; c++)
            if (needOf(c, v0, c0, v1, c1) > mCredit[c]) mStall = 1'b1;
         ok = !mStall && (v0 || v1);
         checkOutput("rnd stall", int'(busIf.stall_dispatch_o), int'(mStall));
         checkOutput("rnd state", int'(busIf.sched_state_o), modelState());
         checkOutput("rnd alu", int'(busIf.credit_alu_o), mCredit[0]);
         checkOutput("rnd lsu", int'(busIf.credit_lsu_o), mCredit[1]);
         checkOutput("rnd bru", int'(busIf.credit_bru_o), mCredit[2]);
         checkOutput("rnd err", int'(busIf.credit_err_o), int'(mErr));
         @(posedge clk);
         if (fl) begin
            for (int c = 0; c < 3; c++) mCredit[c] = NUM;
            quiet = 0;
         end else begin
            quiet++;
            for (int c = 0; c < 3; c++) begin
               nd = mCredit[c] - (ok ? needOf(c, v0, c0, v1, c1) : 0) + int'(iss[c]);
               if (nd > NUM) begin
                  nd = NUM;
                  mErr = 1'b1;
               end
               mCredit[c] = nd;
            end
         end
         sinceReset++;
         @(negedge clk);
      end

      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end
endmodule
